write_back_stage: RTL and testbench

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

---
 rtl/wb_pkg.sv | 32 +++
 rtl/load_align.sv | 36 +++
 rtl/write_back_stage.sv | 178 +++++++++++++++++
 tb/tb_write_back_stage.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: datapath widths, load funct3 encodings,
// arbitration state and the queued load entry layout.
package wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        GrantAlu = 1'b0,
        GrantMem = 1'b1
    } grantT;

    // Loads are queued raw; alignment happens on the FIFO head.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic [2:0]            funct3;
        logic [1:0]            addrLow;
    } memEntryT;

    // x0 is hard-wired, so a write to it is never issued.
    function automatic logic writeQualify(input logic we, input logic [REG_ADDR_W-1:0] rd);
        return we && (rd != '0);
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction: selects byte/halfword/word from the loaded word and
// sign- or zero-extends it according to funct3.
module load_align
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] memData,
    input  logic [2:0]      memFunct3,
    input  logic [1:0]      memAddrLow,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        case (memAddrLow)
            2'd0:    byteSel = memData[7:0];
            2'd1:    byteSel = memData[15:8];
            2'd2:    byteSel = memData[23:16];
            default: byteSel = memData[31:24];
        endcase
        halfSel = memAddrLow[1] ? memData[31:16] : memData[15:0];
    end

    // Unused encodings (011, 110, 111) fall through to a full-word load.
    always_comb begin
        case (memFunct3)
            LB:      data = {{(XLEN-8){byteSel[7]}}, byteSel};
            LBU:     data = {{(XLEN-8){1'b0}}, byteSel};
            LH:      data = {{(XLEN-16){halfSel[15]}}, halfSel};
            LHU:     data = {{(XLEN-16){1'b0}}, halfSel};
            default: data = memData;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: arbitrates a 1-entry ALU holding register and a 2-entry load FIFO onto
// the register file write port. Define WB_BYPASS_EN to add the decode-stage forwarding outputs.
module write_back_stage
    import wb_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetN,

    input  logic                  aluValid,
    output logic                  aluReady,
    input  logic [REG_ADDR_W-1:0] aluRd,
    input  logic [XLEN-1:0]       aluData,
    input  logic                  aluRegWrite,

    input  logic                  memValid,
    output logic                  memReady,
    input  logic [REG_ADDR_W-1:0] memRd,
    input  logic [XLEN-1:0]       memData,
    input  logic [2:0]            memFunct3,
    input  logic [1:0]            memAddrLow,

    output logic [REG_ADDR_W:0]   writeRegister,
    output logic [XLEN-1:0]       writeData,
    output logic                  regWrite
`ifdef WB_BYPASS_EN
    ,
    output logic                  bypassValid,
    output logic [REG_ADDR_W-1:0] bypassRd,
    output logic [XLEN-1:0]       bypassData
`endif
);

    // ALU holding register
    logic                  aluFullQ;
    logic [REG_ADDR_W-1:0] aluRdQ;
    logic [XLEN-1:0]       aluDataQ;
    logic                  aluWeQ;

    // Load FIFO
    memEntryT   fifoQ [2];
    logic [1:0] countQ, countD;
    logic       wrPtrQ, rdPtrQ;
    memEntryT   pushEntry;
    memEntryT   headEntry;
    logic [XLEN-1:0] headAligned;

    grantT lastGrantQ;

    logic memPend;
    logic grantAlu, grantMem, anyGrant;
    logic aluPush, memPush, memPop;

    logic                  selValid;
    logic [REG_ADDR_W-1:0] selRd;
    logic [XLEN-1:0]       selData;

    // Arbitration: a lone pending head wins; on contention the side not served last wins.
    always_comb begin
        memPend  = (countQ != 2'd0);
        grantAlu = aluFullQ && (!memPend || (lastGrantQ == GrantMem));
        grantMem = memPend && (!aluFullQ || (lastGrantQ == GrantAlu));
        anyGrant = grantAlu || grantMem;
    end

    // Readies depend only on state and grants, never on the same channel's valid.
    assign aluReady = resetN && (!aluFullQ || grantAlu);
    assign memReady = resetN && ((countQ != 2'd2) || grantMem);

    assign aluPush = aluValid && aluReady;
    assign memPush = memValid && memReady;
    assign memPop  = grantMem;

    always_comb begin
        pushEntry.rd      = memRd;
        pushEntry.data    = memData;
        pushEntry.funct3  = memFunct3;
        pushEntry.addrLow = memAddrLow;
        headEntry         = fifoQ[rdPtrQ];
    end

    load_align uLoadAlign (
        .memData    (headEntry.data),
        .memFunct3  (headEntry.funct3),
        .memAddrLow (headEntry.addrLow),
        .data       (headAligned)
    );

    always_comb begin
        selValid = 1'b0;
        selRd    = '0;
        selData  = '0;
        if (grantAlu) begin
            selValid = writeQualify(aluWeQ, aluRdQ);
            selRd    = aluRdQ;
            selData  = aluDataQ;
        end else if (grantMem) begin
            selValid = writeQualify(1'b1, headEntry.rd);
            selRd    = headEntry.rd;
            selData  = headAligned;
        end
    end

    always_comb begin
        countD = countQ;
        if (memPush && !memPop) begin
            countD = countQ + 2'd1;
        end else if (!memPush && memPop) begin
            countD = countQ - 2'd1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            aluFullQ <= 1'b0;
            aluRdQ   <= '0;
            aluDataQ <= '0;
            aluWeQ   <= 1'b0;
        end else if (aluPush) begin
            aluFullQ <= 1'b1;
            aluRdQ   <= aluRd;
            aluDataQ <= aluData;
            aluWeQ   <= aluRegWrite;
        end else if (grantAlu) begin
            aluFullQ <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fifoQ[0] <= '0;
            fifoQ[1] <= '0;
            countQ   <= 2'd0;
            wrPtrQ   <= 1'b0;
            rdPtrQ   <= 1'b0;
        end else begin
            if (memPush) begin
                fifoQ[wrPtrQ] <= pushEntry;
                wrPtrQ        <= ~wrPtrQ;
            end
            if (memPop) begin
                rdPtrQ <= ~rdPtrQ;
            end
            countQ <= countD;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            lastGrantQ <= GrantAlu;
        end else if (grantAlu) begin
            lastGrantQ <= GrantAlu;
        end else if (grantMem) begin
            lastGrantQ <= GrantMem;
        end
    end

    // Address/data follow every grant, even suppressed ones; regWrite only pulses when qualified.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else begin
            regWrite <= selValid;
            if (anyGrant) begin
                writeRegister <= {1'b0, selRd};
                writeData     <= selData;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign bypassValid = selValid;
    assign bypassRd    = selRd;
    assign bypassData  = selData;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Directed self-checking bench for write_back_stage; checks bypass outputs when WB_BYPASS_EN
// is defined.
module tb_write_back_stage;

    logic        clock = 1'b0;
    logic        resetN = 1'b1;
    logic        aluValid;
    logic        aluReady;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        aluRegWrite;
    logic        memValid;
    logic        memReady;
    logic [4:0]  memRd;
    logic [31:0] memData;
    logic [2:0]  memFunct3;
    logic [1:0]  memAddrLow;
    logic [5:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
`ifdef WB_BYPASS_EN
    logic        bypassValid;
    logic [4:0]  bypassRd;
    logic [31:0] bypassData;
`endif

    int passCount  = 0;
    int checkCount = 0;

    always #5 clock = ~clock;

    write_back_stage dut (
        .clock         (clock),
        .resetN        (resetN),
        .aluValid      (aluValid),
        .aluReady      (aluReady),
        .aluRd         (aluRd),
        .aluData       (aluData),
        .aluRegWrite   (aluRegWrite),
        .memValid      (memValid),
        .memReady      (memReady),
        .memRd         (memRd),
        .memData       (memData),
        .memFunct3     (memFunct3),
        .memAddrLow    (memAddrLow),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .regWrite      (regWrite)
`ifdef WB_BYPASS_EN
        ,
        .bypassValid   (bypassValid),
        .bypassRd      (bypassRd),
        .bypassData    (bypassData)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idleInputs();
        aluValid    = 1'b0;
        aluRd       = '0;
        aluData     = '0;
        aluRegWrite = 1'b0;
        memValid    = 1'b0;
        memRd       = '0;
        memData     = '0;
        memFunct3   = 3'b010;
        memAddrLow  = '0;
    endtask

    task automatic doReset();
        idleInputs();
        resetN = 1'b0;
        repeat (2) @(posedge clock);
        #2 resetN = 1'b1;
    endtask

    task automatic test_reset();
        idleInputs();
        #1 resetN = 1'b0;
        #1;
        checkCount++;
        if ({regWrite, writeRegister, writeData, aluReady, memReady} !== '0)
            $display("FAIL reset_outputs: got rw=%0b wr=%0d wd=%h ar=%0b mr=%0b want all 0",
                     regWrite, writeRegister, writeData, aluReady, memReady);
        else passCount++;
        repeat (2) @(posedge clock);
        #2 resetN = 1'b1;
        #1;
        checkCount++;
        if ({aluReady, memReady} !== 2'b11)
            $display("FAIL reset_release_ready: got %b want 11", {aluReady, memReady});
        else passCount++;
    endtask

    task automatic test_alu_uncontended();
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'h12345678; aluRegWrite = 1'b1;
        #1;
        checkCount++;
        if (aluReady !== 1'b1) $display("FAIL alu_ready_idle: got %0b want 1", aluReady);
        else passCount++;
        tick();
        aluValid = 1'b0;
        checkCount++;
        if (regWrite !== 1'b0) $display("FAIL alu_latency_early: got rw=%0b want 0", regWrite);
        else passCount++;
        tick();
        checkCount++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 6'd5, 32'h12345678})
            $display("FAIL alu_write: got rw=%0b wr=%0d wd=%h want 1/5/12345678",
                     regWrite, writeRegister, writeData);
        else passCount++;
        tick();
        checkCount++;
        if ({regWrite, writeRegister, writeData} !== {1'b0, 6'd5, 32'h12345678})
            $display("FAIL alu_pulse_hold: got rw=%0b wr=%0d wd=%h want 0/5/12345678",
                     regWrite, writeRegister, writeData);
        else passCount++;
    endtask

    logic [2:0]  alF3  [9] = '{3'b000, 3'b100, 3'b001, 3'b111, 3'b000, 3'b101, 3'b010,
                               3'b011, 3'b110};
    logic [1:0]  alAdr [9] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd3};
    logic [31:0] alExp [9] = '{32'h0000007F, 32'h00000080, 32'hFFFF80FF, 32'h80FF7F01,
                               32'hFFFFFF80, 32'h00007F01, 32'h80FF7F01, 32'h80FF7F01,
                               32'h80FF7F01};

    task automatic test_load_align();
        for (int i = 0; i < 9; i++) begin
            memValid = 1'b1; memRd = 5'd9; memData = 32'h80FF7F01;
            memFunct3 = alF3[i]; memAddrLow = alAdr[i];
            tick();
            memValid = 1'b0;
            tick();
            checkCount++;
            if ({regWrite, writeRegister, writeData} !== {1'b1, 6'd9, alExp[i]})
                $display("FAIL load_align_%0d: got rw=%0b wr=%0d wd=%h want 1/9/%h",
                         i, regWrite, writeRegister, writeData, alExp[i]);
            else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        aluValid = 1'b1; aluRegWrite = 1'b1; aluRd = 5'd1; aluData = 32'h0000_0B01;
        tick();
        aluRd = 5'd2; aluData = 32'h0000_0B02;
        #1;
        checkCount++;
        if (aluReady !== 1'b1) $display("FAIL b2b_ready: got %0b want 1", aluReady);
        else passCount++;
        tick();
        checkCount++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 6'd1, 32'h0000_0B01})
            $display("FAIL b2b_first: got rw=%0b wr=%0d wd=%h", regWrite, writeRegister, writeData);
        else passCount++;
        aluRd = 5'd3; aluData = 32'h0000_0B03;
        tick();
        checkCount++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 6'd2, 32'h0000_0B02})
            $display("FAIL b2b_second: got rw=%0b wr=%0d wd=%h", regWrite, writeRegister, writeData);
        else passCount++;
        aluValid = 1'b0;
        tick();
        checkCount++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 6'd3, 32'h0000_0B03})
            $display("FAIL b2b_third: got rw=%0b wr=%0d wd=%h", regWrite, writeRegister, writeData);
        else passCount++;
        tick();
        checkCount++;
        if (regWrite !== 1'b0) $display("FAIL b2b_idle: got rw=%0b want 0", regWrite);
        else passCount++;
    endtask

    // Per-cycle stimulus and expectations for two channels held valid for four cycles.
    logic        cAluV [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [4:0]  cAluRd[8] = '{5'd1, 5'd2, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] cAluD [8] = '{32'hA0000001, 32'hA1000002, 32'hA1000002, 32'hA2000003,
                               32'h0, 32'h0, 32'h0, 32'h0};
    logic        cMemV [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [4:0]  cMemRd[8] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] cMemD [8] = '{32'h10000000, 32'h11000000, 32'h12000000, 32'h13000000,
                               32'h0, 32'h0, 32'h0, 32'h0};
    logic        cARdy [8] = '{1, 0, 1, 0, 1, 1, 1, 1};
    logic        cMRdy [8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    logic        eV    [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    logic [5:0]  eRd   [9] = '{6'd0, 6'd0, 6'd10, 6'd1, 6'd11, 6'd2, 6'd12, 6'd13, 6'd0};
    logic [31:0] eD    [9] = '{32'h0, 32'h0, 32'h10000000, 32'hA0000001, 32'h11000000,
                               32'hA1000002, 32'h12000000, 32'h13000000, 32'h0};

    task automatic test_contention();
        logic [5:0] rdTmp;
        doReset();
        aluRegWrite = 1'b1;
        memFunct3   = 3'b010;
        memAddrLow  = 2'd0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                checkCount++;
                if (eV[k]) begin
                    if ({regWrite, writeRegister, writeData} !== {1'b1, eRd[k], eD[k]})
                        $display("FAIL contention_out_%0d: got rw=%0b wr=%0d wd=%h want 1/%0d/%h",
                                 k, regWrite, writeRegister, writeData, eRd[k], eD[k]);
                    else passCount++;
                end else begin
                    if (regWrite !== 1'b0)
                        $display("FAIL contention_out_%0d: got rw=%0b want 0", k, regWrite);
                    else passCount++;
                end
            end
            if (k < 8) begin
                aluValid = cAluV[k]; aluRd = cAluRd[k]; aluData = cAluD[k];
                memValid = cMemV[k]; memRd = cMemRd[k]; memData = cMemD[k];
                #1;
                checkCount++;
                if ({aluReady, memReady} !== {cARdy[k], cMRdy[k]})
                    $display("FAIL contention_ready_%0d: got ar=%0b mr=%0b want ar=%0b mr=%0b",
                             k, aluReady, memReady, cARdy[k], cMRdy[k]);
                else passCount++;
`ifdef WB_BYPASS_EN
                rdTmp = eRd[k+1];
                checkCount++;
                if (eV[k+1]) begin
                    if ({bypassValid, bypassRd, bypassData} !== {1'b1, rdTmp[4:0], eD[k+1]})
                        $display("FAIL bypass_%0d: got v=%0b rd=%0d d=%h want 1/%0d/%h",
                                 k, bypassValid, bypassRd, bypassData, rdTmp, eD[k+1]);
                    else passCount++;
                end else begin
                    if (bypassValid !== 1'b0)
                        $display("FAIL bypass_%0d: got v=%0b want 0", k, bypassValid);
                    else passCount++;
                end
`else
                rdTmp = '0;
`endif
                tick();
            end
        end
        idleInputs();
    endtask

    task automatic test_suppression();
        aluValid = 1'b1; aluRd = 5'd0; aluData = 32'hDEADBEEF; aluRegWrite = 1'b1;
        tick();
        aluRd = 5'd7; aluData = 32'h00000077; aluRegWrite = 1'b0;
        #1;
        checkCount++;
        if ({aluReady, regWrite} !== 2'b10)
            $display("FAIL suppress_accept: got ar=%0b rw=%0b want ar=1 rw=0", aluReady, regWrite);
        else passCount++;
        tick();
        aluValid = 1'b0;
        checkCount++;
        if ({regWrite, writeRegister, writeData} !== {1'b0, 6'd0, 32'hDEADBEEF})
            $display("FAIL suppress_rd0: got rw=%0b wr=%0d wd=%h want 0/0/deadbeef",
                     regWrite, writeRegister, writeData);
        else passCount++;
        tick();
        checkCount++;
        if ({regWrite, writeRegister, writeData} !== {1'b0, 6'd7, 32'h00000077})
            $display("FAIL suppress_we0: got rw=%0b wr=%0d wd=%h want 0/7/00000077",
                     regWrite, writeRegister, writeData);
        else passCount++;
        tick();
        checkCount++;
        if ({regWrite, aluReady} !== 2'b01)
            $display("FAIL suppress_drain: got rw=%0b ar=%0b want rw=0 ar=1", regWrite, aluReady);
        else passCount++;
    endtask

    task automatic test_reset_mid_flow();
        doReset();
        aluValid = 1'b1; aluRd = 5'd4; aluData = 32'h44; aluRegWrite = 1'b1;
        memValid = 1'b1; memRd = 5'd20; memData = 32'h20; memFunct3 = 3'b010; memAddrLow = 2'd0;
        tick();
        aluRd = 5'd5; aluData = 32'h55;
        memRd = 5'd21; memData = 32'h21;
        tick();
        memRd = 5'd22; memData = 32'h22;
        tick();
        idleInputs();
        #1;
        checkCount++;
        if ({aluReady, memReady} !== 2'b01)
            $display("FAIL midflow_full: got ar=%0b mr=%0b want ar=0 mr=1", aluReady, memReady);
        else passCount++;
        resetN = 1'b0;
        #1;
        checkCount++;
        if ({regWrite, writeRegister, writeData, aluReady, memReady} !== '0)
            $display("FAIL midflow_reset_outputs: got rw=%0b wr=%0d wd=%h ar=%0b mr=%0b",
                     regWrite, writeRegister, writeData, aluReady, memReady);
        else passCount++;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkCount++;
            if (regWrite !== 1'b0)
                $display("FAIL midflow_in_reset_%0d: got rw=%0b want 0", i, regWrite);
            else passCount++;
        end
        resetN = 1'b1;
        #1;
        checkCount++;
        if ({aluReady, memReady} !== 2'b11)
            $display("FAIL midflow_release_ready: got %b want 11", {aluReady, memReady});
        else passCount++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++;
            if ({regWrite, writeRegister, writeData} !== '0)
                $display("FAIL midflow_discard_%0d: got rw=%0b wr=%0d wd=%h want 0",
                         i, regWrite, writeRegister, writeData);
            else passCount++;
        end
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_alu_uncontended();
        test_load_align();
        test_back_to_back();
        test_contention();
        test_suppression();
        test_reset_mid_flow();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
